fire_suppression_scheduler: RTL and testbench

- Shares one suppression pump between NUM_ZONES fire zones.
- Each zone's fire controller drives its extinguish request into this block.
- The block primes the pump, opens exactly one zone valve at a time, and rotates between zones round-robin with minimum and maximum spray windows.
- A purge interval separates valve changes.
- It also combines all zone alarms into one building siren.

---
 rtl/fire_suppression_scheduler.sv | 177 +++++++++++++++++
 tb/tb_fire_suppression_scheduler.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fire_suppression_scheduler.sv
// Shared suppression pump scheduler: primes the pump, grants one zone valve
// at a time round-robin with min/max spray windows and purge gaps.
module fire_suppression_scheduler #(
    parameter int NUM_ZONES    = 4,
    parameter int PRIME_CYCLES = 4,
    parameter int MIN_SPRAY    = 8,
    parameter int MAX_SPRAY    = 32,
    parameter int PURGE_CYCLES = 2,
    localparam int AW = (NUM_ZONES > 1) ? $clog2(NUM_ZONES) : 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 enable,
    input  logic [NUM_ZONES-1:0] zone_req,
    input  logic [NUM_ZONES-1:0] zone_alarm,
    output logic                 pump_on,
    output logic [NUM_ZONES-1:0] valve_sel,
    output logic [AW-1:0]        active_zone,
    output logic                 busy,
    output logic                 zone_served,
    output logic                 siren
);

    localparam int CW = $clog2(MAX_SPRAY + PRIME_CYCLES + PURGE_CYCLES + 1);

    typedef enum logic [1:0] {
        IDLE,
        PRIME,
        SPRAY,
        PURGE
    } state_t;

    state_t                 state_q;
    state_t                 state_n;
    logic [CW-1:0]          cnt_q;
    logic [CW-1:0]          cnt_n;
    logic [AW-1:0]          rr_q;
    logic [AW-1:0]          rr_n;
    logic [AW-1:0]          act_n;
    logic [AW-1:0]          act_inc;
    logic [AW-1:0]          pick_idx;
    logic                   pick_found;
    logic [AW:0]            pick_sum;
    logic [2*NUM_ZONES-1:0] req_rot;
    logic [NUM_ZONES-1:0]   own_mask;
    logic [NUM_ZONES-1:0]   next_mask;
    logic                   own_req;
    logic                   other_req;
    logic                   spray_done;
    logic                   served_n;

    // Rotate so bit i of req_rot is zone (rr_q + i) mod NUM_ZONES.
    assign req_rot = {zone_req, zone_req} >> rr_q;

    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        pick_sum   = '0;
        for (int i = 0; i < NUM_ZONES; i++) begin
            if (!pick_found && req_rot[i]) begin
                pick_found = 1'b1;
                pick_sum   = {1'b0, rr_q} + (AW+1)'(i);
                if (pick_sum >= (AW+1)'(NUM_ZONES)) begin
                    pick_sum = pick_sum - (AW+1)'(NUM_ZONES);
                end
                pick_idx = pick_sum[AW-1:0];
            end
        end
    end

    always_comb begin
        own_mask  = '0;
        next_mask = '0;
        for (int i = 0; i < NUM_ZONES; i++) begin
            own_mask[i]  = (active_zone == AW'(i));
            next_mask[i] = (act_n == AW'(i));
        end
    end

    assign own_req   = |(zone_req & own_mask);
    assign other_req = |(zone_req & ~own_mask);

    assign act_inc = (active_zone == AW'(NUM_ZONES - 1)) ?
                     '0 : active_zone + AW'(1);

    assign spray_done = !enable ||
                        ((cnt_q >= CW'(MIN_SPRAY)) && !own_req) ||
                        ((cnt_q >= CW'(MAX_SPRAY)) && other_req);

    always_comb begin
        state_n  = state_q;
        cnt_n    = cnt_q;
        act_n    = active_zone;
        rr_n     = rr_q;
        served_n = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (enable && pick_found) begin
                    state_n = PRIME;
                    act_n   = pick_idx;
                    cnt_n   = CW'(1);
                end
            end
            PRIME: begin
                if (!enable || !own_req) begin
                    state_n = PURGE;
                    cnt_n   = CW'(1);
                end else if (cnt_q == CW'(PRIME_CYCLES)) begin
                    state_n = SPRAY;
                    cnt_n   = CW'(1);
                end else begin
                    cnt_n = cnt_q + CW'(1);
                end
            end
            SPRAY: begin
                if (spray_done) begin
                    state_n  = PURGE;
                    cnt_n    = CW'(1);
                    served_n = 1'b1;
                    rr_n     = act_inc;
                end else if (cnt_q != CW'(MAX_SPRAY)) begin
                    cnt_n = cnt_q + CW'(1);
                end
            end
            PURGE: begin
                if (cnt_q == CW'(PURGE_CYCLES)) begin
                    // Pump is still primed, so a new grant skips PRIME.
                    if (enable && pick_found) begin
                        state_n = SPRAY;
                        act_n   = pick_idx;
                        cnt_n   = CW'(1);
                    end else begin
                        state_n = IDLE;
                        cnt_n   = '0;
                    end
                end else begin
                    cnt_n = cnt_q + CW'(1);
                end
            end
            default: begin
                state_n = IDLE;
                cnt_n   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            rr_q        <= '0;
            active_zone <= '0;
            pump_on     <= 1'b0;
            valve_sel   <= '0;
            busy        <= 1'b0;
            zone_served <= 1'b0;
            siren       <= 1'b0;
        end else begin
            state_q     <= state_n;
            cnt_q       <= cnt_n;
            rr_q        <= rr_n;
            active_zone <= act_n;
            pump_on     <= (state_n != IDLE);
            valve_sel   <= (state_n == SPRAY) ? next_mask : '0;
            busy        <= (state_n != IDLE);
            zone_served <= served_n;
            siren       <= |(zone_req | zone_alarm);
        end
    end

    a_valve_onehot: assert property (
        @(posedge clk) disable iff (reset) $onehot0(valve_sel));

    a_valve_pump: assert property (
        @(posedge clk) disable iff (reset) (valve_sel != '0) |-> pump_on);

endmodule

// File: tb/tb_fire_suppression_scheduler.sv
// Bench for fire_suppression_scheduler: directed vector table, corner-case
// sequences and randomized traffic against a cycle-level reference model.
module tb_fire_suppression_scheduler;

    localparam int N      = 4;
    localparam int PRIME  = 4;
    localparam int MINS   = 8;
    localparam int MAXS   = 32;
    localparam int PURGE  = 2;

    logic       clk = 1'b0;
    logic       reset_i = 1'b1;
    logic       enable_i = 1'b1;
    logic [3:0] req_i = 4'b1111;
    logic [3:0] alarm_i = 4'b0000;

    logic       pump_on;
    logic [3:0] valve_sel;
    logic [1:0] active_zone;
    logic       busy;
    logic       zone_served;
    logic       siren;

    int checks = 0;
    int errors = 0;
    bit dual_seen = 0;

    fire_suppression_scheduler #(
        .NUM_ZONES(N),
        .PRIME_CYCLES(PRIME),
        .MIN_SPRAY(MINS),
        .MAX_SPRAY(MAXS),
        .PURGE_CYCLES(PURGE)
    ) dut (
        .clk(clk),
        .reset(reset_i),
        .enable(enable_i),
        .zone_req(req_i),
        .zone_alarm(alarm_i),
        .pump_on(pump_on),
        .valve_sel(valve_sel),
        .active_zone(active_zone),
        .busy(busy),
        .zone_served(zone_served),
        .siren(siren)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic       en;
        logic [3:0] req;
        logic [3:0] alm;
        logic [9:0] exp;
    } vec_t;

    vec_t vecs[$];

    // Reference model: phase 0 idle, 1 prime, 2 spray, 3 purge;
    // m_t counts finished cycles in the current phase, unbounded.
    bit m_valid = 0;
    int m_phase;
    int m_t;
    int m_zone;
    int m_ptr;
    bit m_served;
    bit m_siren;

    function automatic vec_t mk(logic rst, logic en, logic [3:0] req,
                                logic [3:0] alm, logic pump,
                                logic [3:0] valve, logic [1:0] act,
                                logic bsy, logic srv, logic sir);
        vec_t v;
        v.rst = rst;
        v.en  = en;
        v.req = req;
        v.alm = alm;
        v.exp = {pump, valve, act, bsy, srv, sir};
        return v;
    endfunction

    function automatic logic [9:0] got_vec();
        return {pump_on, valve_sel, active_zone, busy, zone_served, siren};
    endfunction

    function automatic int rr_pick(logic [3:0] req, int from);
        for (int i = 0; i < N; i++) begin
            if (req[(from + i) % N]) return (from + i) % N;
        end
        return -1;
    endfunction

    function automatic logic [9:0] model_vec();
        logic [3:0] v;
        logic on;
        on = (m_phase != 0);
        v  = (m_phase == 2) ? 4'(1 << m_zone) : 4'b0000;
        return {on, v, 2'(m_zone), on, m_served, m_siren};
    endfunction

    task automatic model_step();
        int z;
        if (reset_i) begin
            m_valid  = 1;
            m_phase  = 0;
            m_t      = 0;
            m_zone   = 0;
            m_ptr    = 0;
            m_served = 0;
            m_siren  = 0;
            return;
        end
        m_served = 0;
        m_siren  = |(req_i | alarm_i);
        case (m_phase)
            0: begin
                if (enable_i && req_i != 0) begin
                    m_zone  = rr_pick(req_i, m_ptr);
                    m_phase = 1;
                    m_t     = 0;
                end
            end
            1: begin
                m_t++;
                if (!enable_i || !req_i[m_zone]) begin
                    m_phase = 3;
                    m_t     = 0;
                end else if (m_t == PRIME) begin
                    m_phase = 2;
                    m_t     = 0;
                end
            end
            2: begin
                m_t++;
                if (!enable_i ||
                    (m_t >= MINS && !req_i[m_zone]) ||
                    (m_t >= MAXS && (req_i & ~(4'b1 << m_zone)) != 0)) begin
                    m_served = 1;
                    m_ptr    = (m_zone + 1) % N;
                    m_phase  = 3;
                    m_t      = 0;
                end
            end
            default: begin
                m_t++;
                if (m_t == PURGE) begin
                    z = rr_pick(req_i, m_ptr);
                    if (enable_i && z >= 0) begin
                        m_zone  = z;
                        m_phase = 2;
                    end else begin
                        m_phase = 0;
                    end
                    m_t = 0;
                end
            end
        endcase
    endtask

    task automatic check(input string name, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h at %0t",
                     name, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        if (valve_sel == 4'b1001) dual_seen = 1;
        if (m_valid) check("model", 32'(got_vec()), 32'(model_vec()));
    endtask

    task automatic do_reset();
        reset_i = 1'b1;
        tick();
        reset_i = 1'b0;
    endtask

    task automatic run_len(input logic [3:0] v, output int n);
        n = 0;
        while (valve_sel == v && n < 200) begin
            n++;
            tick();
        end
    endtask

    initial begin : main
        int n;
        bit srv_seen;

        for (int i = 0; i < 3; i++)
            vecs.push_back(mk(1, 1, 4'hf, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 4'hf, 0, 0, 0, 0, 0, 0, 1));
        vecs.push_back(mk(0, 1, 4'h0, 0, 0, 0, 0, 0, 0, 0));
        for (int e = 0; e < 4; e++)
            vecs.push_back(mk(0, 1, 4'h4, 0, 1, 4'h0, 2, 1, 0, 1));
        vecs.push_back(mk(0, 1, 4'h4, 0, 1, 4'h4, 2, 1, 0, 1));
        for (int e = 5; e < 12; e++)
            vecs.push_back(mk(0, 1, 4'h0, 0, 1, 4'h4, 2, 1, 0, 0));
        vecs.push_back(mk(0, 1, 4'h0, 0, 1, 4'h0, 2, 1, 1, 0));
        vecs.push_back(mk(0, 1, 4'h0, 0, 1, 4'h0, 2, 1, 0, 0));
        vecs.push_back(mk(0, 1, 4'h0, 0, 0, 4'h0, 2, 0, 0, 0));
        vecs.push_back(mk(0, 1, 4'h0, 4'h8, 0, 4'h0, 2, 0, 0, 1));

        foreach (vecs[i]) begin
            reset_i  = vecs[i].rst;
            enable_i = vecs[i].en;
            req_i    = vecs[i].req;
            alarm_i  = vecs[i].alm;
            tick();
            check($sformatf("vec%0d", i), 32'(got_vec()), 32'(vecs[i].exp));
        end
        alarm_i = 0;

        // Round-robin between zones 0 and 3 with MAX_SPRAY yielding.
        do_reset();
        req_i = 4'b1001;
        tick();
        repeat (PRIME) tick();
        run_len(4'b0001, n);
        check("rr_zone0_len", n, MAXS);
        run_len(4'b0000, n);
        check("rr_purge_len", n, PURGE);
        check("rr_zone3", valve_sel, 4'b1000);
        run_len(4'b1000, n);
        check("rr_zone3_len", n, MAXS);
        run_len(4'b0000, n);
        check("rr_purge2_len", n, PURGE);
        check("rr_zone0_again", valve_sel, 4'b0001);
        check("rr_no_dual", dual_seen, 0);

        // Enable dropped during SPRAY cycle 3 of zone 1.
        do_reset();
        req_i = 4'b0010;
        tick();
        repeat (6) tick();
        check("abort_pre", valve_sel, 4'b0010);
        enable_i = 1'b0;
        tick();
        check("abort_purge", {valve_sel, zone_served, busy}, {4'b0, 1'b1, 1'b1});
        tick();
        tick();
        check("abort_idle", {pump_on, busy}, 2'b00);
        tick();
        check("abort_stay_idle", {pump_on, valve_sel}, 5'b0);
        enable_i = 1'b1;
        req_i    = 4'b0000;

        // Request withdrawn during PRIME cycle 2.
        do_reset();
        req_i = 4'b0010;
        tick();
        tick();
        req_i = 4'b0000;
        tick();
        srv_seen = zone_served;
        check("prime_drop_purge", {pump_on, valve_sel, busy}, {1'b1, 4'b0, 1'b1});
        tick();
        srv_seen |= zone_served;
        check("prime_drop_valve", valve_sel, 4'b0);
        tick();
        check("prime_drop_idle", {pump_on, busy}, 2'b00);
        check("prime_drop_no_srv", srv_seen, 0);

        // Reset during SPRAY cycle 4 of zone 2.
        do_reset();
        req_i = 4'b0100;
        tick();
        repeat (7) tick();
        check("rst_spray_pre", valve_sel, 4'b0100);
        reset_i = 1'b1;
        tick();
        check("rst_spray_off", {pump_on, valve_sel, busy}, 6'b0);
        reset_i = 1'b0;
        tick();
        check("rst_reprime", {pump_on, valve_sel, active_zone},
              {1'b1, 4'b0, 2'd2});
        repeat (PRIME) tick();
        check("rst_respray", valve_sel, 4'b0100);
        req_i = 4'b0000;

        // Randomized traffic against the reference model.
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 7) == 0)
                req_i = req_i ^ 4'(1 << $urandom_range(0, 3));
            if (enable_i && $urandom_range(0, 49) == 0)
                enable_i = 1'b0;
            else if (!enable_i && $urandom_range(0, 3) == 0)
                enable_i = 1'b1;
            if ($urandom_range(0, 9) == 0)
                alarm_i = 4'($urandom_range(0, 15));
            reset_i = ($urandom_range(0, 399) == 0);
            tick();
        end
        check("rand_no_dual", dual_seen, 0);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
